gpr_bank: RTL and testbench
===========================

# gpr_bank

Parametrised general-purpose register bank for the processor datapath. It has a handshaked bus port (cs/req/write → rdy/ack) for controller-driven loads and stores, a direct datapath write port, and NUM_RD combinational read ports for operand fetch. Data paths are split into separate input and output buses, with no tristate. It replaces the fixed 16×8 single-port register file and adds reset, range checking, an optional hardwired zero register and multi-port access.

## Interface
- DATA_WIDTH, 16, register width in bits
- ADDR_WIDTH, 16, bus address width
- DEPTH, 8, number of registers (≥2, need not be a power of 2)
- NUM_RD, 2, number of datapath read ports (≥1)
- ZERO_REG, 0, if 1 register 0 always reads 0 and ignores writes
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- cs  in  1  bus chip select
- req  in  1  bus request; a transfer is accepted on the edge where cs & req & rdy
- write  in  1  1 = store to register, 0 = load from register; sampled at accept
- address  in  ADDR_WIDTH  bus register address; sampled at accept
- wdata  in  DATA_WIDTH  bus store data; sampled at accept
- rdata  out  DATA_WIDTH  bus load data; valid while ack=1
- rdy  out  1  bank idle and able to accept a transfer
- ack  out  1  one-cycle completion pulse
- err  out  1  with ack: address ≥ DEPTH
- dp_we  in  1  datapath write enable
- dp_waddr  in  $clog2(DEPTH)  datapath write index
- dp_wdata  in  DATA_WIDTH  datapath write data
- rd_addr  in  NUM_RD*$clog2(DEPTH)  packed read indices, port i in slice i
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data, port i in slice i

## Operation
- Bus FSM states: IDLE → ACCESS → DONE → IDLE.
- IDLE: rdy=1. On accept, capture write, address and wdata, then go to ACCESS.
- ACCESS: rdy=0.
  - At the edge leaving ACCESS, a store commits to GPR[address].
  - At the same edge, a load registers GPR[address] into rdata.
  - Go to DONE.
- DONE: ack=1 and rdy=0 for exactly one cycle. rdata holds until the next load completes. Return to IDLE.
- cs or req deasserting after accept does not abort the transfer.
- Out of range (address ≥ DEPTH, full ADDR_WIDTH compare): a store writes nothing; a load returns rdata=0. err=1 during the DONE cycle, 0 otherwise.
- ZERO_REG=1: writes to index 0 from either port are dropped without err, and every read of index 0 returns 0.
- dp_we=1 writes dp_wdata to GPR[dp_waddr] at that edge, independent of the FSM. dp_waddr ≥ DEPTH is ignored.
- Simultaneous bus commit and dp write at the same edge:
  - Different indices: both commit.
  - Same index: the datapath value wins.
- A bus load in ACCESS samples the array before that edge's writes, so there is no bypass.
- rd_data[i] = GPR[rd_addr[i]] combinationally.
  - An out-of-range index returns 0.
  - There is no write bypass; a write is visible from the cycle after its edge.

## Timing
- Reset (rst=1 at an edge): every register is cleared to 0 and the FSM goes to IDLE. After that edge: rdy=1, ack=0, err=0, rdata=0.
- rst has priority at the edge where it is sampled. A store in ACCESS at that edge does not commit, and a pending ack is never issued.
- Accept at edge N: store commits at N+1; ack/err/rdata are valid in cycle N+1→N+2; rdy returns at N+2.
- Earliest next accept is edge N+3, so bus throughput is one transfer per 3 cycles.
- Datapath write latency is 1 edge. Read ports have zero cycles of latency.

## Structure
- Package gpr_pkg:
  - state typedef gpr_state_t {IDLE, ACCESS, DONE}
  - index-width helper localparam
- Sub-module gpr_bus_ctrl: handshake FSM plus capture registers. It outputs rdy, ack and the commit/load strobes.
- gpr_bank holds the array, write arbitration, range/zero masking and the read-port generate loop.

## Test plan
- Reset: drive rst for 2 cycles → every rd_data=0, rdy=1, ack=0, rdata=0.
- Bus store: address=3, wdata=16'hA5A5 → ack 2 cycles after accept with err=0. rd_data at index 3 = 16'hA5A5 from the cycle after commit. A bus load from 3 returns rdata=16'hA5A5.
- Out of range: bus store to address=8 (DEPTH=8) → ack with err=1 and all registers unchanged. A load from 16'hFFFF gives rdata=0 and err=1.
- Collision: bus store of 16'h1111 to index 5 committing on the same edge as dp_we with index 5, data 16'h2222 → GPR[5]=16'h2222. Repeat with dp index 6 → GPR[5]=16'h1111 and GPR[6]=16'h2222.
- ZERO_REG=1: bus store of 16'hFFFF to 0 and dp write to 0 → ack with err=0, and index 0 reads 0 on all ports.
- Reset mid-op: accept a store of 16'hBEEF to index 2 and assert rst at the next edge → GPR[2]=0, no ack pulse, rdy=1 after reset.

Source files
------------

// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared types and helpers for the general-purpose register bank
//
// Purpose : bus FSM state encoding and the index-width helper used by gpr_bank.
// Contents: gpr_state_t, GPR_MIN_DEPTH, gpr_idx_w().

package gpr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } gpr_state_t;

    // Smallest bank the index arithmetic is meant for; a 1-entry bank would
    // need a zero-width index.
    localparam int GPR_MIN_DEPTH = 2;

    // Register index width for a bank of the given depth.
    function automatic int gpr_idx_w(input int depth);
        return (depth < GPR_MIN_DEPTH) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/gpr_bus_ctrl.sv
// rtl/gpr_bus_ctrl.sv - bus handshake FSM and transfer capture registers
//
// Purpose : accepts one bus transfer at a time (IDLE -> ACCESS -> DONE) and
//           holds its write flag, address and data until it completes.
// Ports   : clk, rst              clock, synchronous active-high reset
//           cs, req, write        bus handshake and direction
//           address, wdata        bus address and store data
//           rdy, ack              idle indication, one-cycle completion pulse
//           store_stb, load_stb   high in ACCESS; the edge leaving ACCESS commits
//           cap_addr, cap_wdata   captured address and store data

module gpr_bus_ctrl
    import gpr_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  req,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdy,
    output logic                  ack,
    output logic                  store_stb,
    output logic                  load_stb,
    output logic [ADDR_WIDTH-1:0] cap_addr,
    output logic [DATA_WIDTH-1:0] cap_wdata
);

    gpr_state_t            state_q, state_d;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  accept;

    assign accept = (state_q == IDLE) && cs && req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= write;
            addr_q  <= address;
            wdata_q <= wdata;
        end
    end

    // cs/req are only looked at in IDLE, so dropping them later cannot abort.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdy       = (state_q == IDLE);
        ack       = (state_q == DONE);
        store_stb = (state_q == ACCESS) &&  write_q;
        load_stb  = (state_q == ACCESS) && !write_q;
    end

    assign cap_addr  = addr_q;
    assign cap_wdata = wdata_q;

endmodule

// File: rtl/gpr_bank.sv
// rtl/gpr_bank.sv - parametrised multi-port general-purpose register bank
//
// Purpose : register array with a handshaked bus port, a direct datapath
//           write port and NUM_RD combinational read ports.
// Ports   : clk, rst                  clock, synchronous active-high reset
//           cs, req, write, address,  bus transfer request
//           wdata
//           rdata, rdy, ack, err      bus load data, idle, completion, range error
//           dp_we, dp_waddr, dp_wdata datapath write port
//           rd_addr, rd_data          packed read indices / data, port i in slice i

module gpr_bank
    import gpr_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cs,
    input  logic                                req,
    input  logic                                write,
    input  logic [ADDR_WIDTH-1:0]               address,
    input  logic [DATA_WIDTH-1:0]               wdata,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic                                rdy,
    output logic                                ack,
    output logic                                err,
    input  logic                                dp_we,
    input  logic [$clog2(DEPTH)-1:0]            dp_waddr,
    input  logic [DATA_WIDTH-1:0]               dp_wdata,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0]     rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]        rd_data
);

    localparam int IW = gpr_idx_w(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IW:0]         DEPTH_I = (IW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] gpr_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  store_stb, load_stb;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [IW-1:0]         bus_idx;
    logic                  bus_ok, bus_zero, bus_we, dp_ok;
    logic [DATA_WIDTH-1:0] bus_rd_word;

    gpr_bus_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .req       (req),
        .write     (write),
        .address   (address),
        .wdata     (wdata),
        .rdy       (rdy),
        .ack       (ack),
        .store_stb (store_stb),
        .load_stb  (load_stb),
        .cap_addr  (cap_addr),
        .cap_wdata (cap_wdata)
    );

    // Range check uses the full bus address, not just the index bits.
    assign bus_ok   = {1'b0, cap_addr} < DEPTH_A;
    assign bus_idx  = cap_addr[IW-1:0];
    assign bus_zero = (ZERO_REG != 0) && (bus_idx == '0);
    assign bus_we   = store_stb && bus_ok && !bus_zero;
    assign dp_ok    = dp_we && ({1'b0, dp_waddr} < DEPTH_I)
                      && !((ZERO_REG != 0) && (dp_waddr == '0));

    // Pre-edge array contents: a load never sees a write landing on the same edge.
    assign bus_rd_word = (bus_ok && !bus_zero) ? gpr_q[bus_idx] : '0;

    // The datapath assignment comes last so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) gpr_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus_we && (bus_idx == IW'(i))) gpr_q[i] <= cap_wdata;
                if (dp_ok && (dp_waddr == IW'(i))) gpr_q[i] <= dp_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (load_stb) rdata_q <= bus_rd_word;
            err_q <= (store_stb || load_stb) && !bus_ok;
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [IW-1:0] idx;
        assign idx = rd_addr[p*IW +: IW];
        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
            (({1'b0, idx} < DEPTH_I) && !((ZERO_REG != 0) && (idx == '0))) ? gpr_q[idx] : '0;
    end

endmodule

// File: tb/tb_gpr_bank.sv
// tb/tb_gpr_bank.sv - scoreboard bench for gpr_bank (ZERO_REG=0 and ZERO_REG=1 instances)

module tb_gpr_bank;

    logic        clk = 1'b0;
    logic        rst, cs, req, write, dp_we;
    logic [15:0] address, wdata, dp_wdata;
    logic [2:0]  dp_waddr;
    logic [5:0]  rd_addr;
    logic [15:0] rdata, rdata_z;
    logic        rdy, ack, err, rdy_z, ack_z, err_z;
    logic [31:0] rd_data, rd_data_z;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic [15:0] rdata_z;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] m  [8];
    logic [15:0] mz [8];

    always #5 clk = ~clk;

    gpr_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(8), .NUM_RD(2), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .cs(cs), .req(req), .write(write), .address(address),
        .wdata(wdata), .rdata(rdata), .rdy(rdy), .ack(ack), .err(err),
        .dp_we(dp_we), .dp_waddr(dp_waddr), .dp_wdata(dp_wdata),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    gpr_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(8), .NUM_RD(2), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .cs(cs), .req(req), .write(write), .address(address),
        .wdata(wdata), .rdata(rdata_z), .rdy(rdy_z), .ack(ack_z), .err(err_z),
        .dp_we(dp_we), .dp_waddr(dp_waddr), .dp_wdata(dp_wdata),
        .rd_addr(rd_addr), .rd_data(rd_data_z)
    );

    // Monitor: every ack pops one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (ack === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack t=%0t got ack=1 want no ack", $time);
            end else begin
                e = sb_q.pop_front();
                if (rdata !== e.rdata || err !== e.err) begin
                    bad++;
                    $display("FAIL ack_resp t=%0t got rdata=%h err=%b want rdata=%h err=%b",
                             $time, rdata, err, e.rdata, e.err);
                end
                total++;
                if (ack_z !== 1'b1 || rdata_z !== e.rdata_z || err_z !== e.err) begin
                    bad++;
                    $display("FAIL ack_resp_z t=%0t got ack=%b rdata=%h err=%b want ack=1 rdata=%h err=%b",
                             $time, ack_z, rdata_z, err_z, e.rdata_z, e.err);
                end
            end
        end else if (err === 1'b1 || ack_z === 1'b1) begin
            total++;
            bad++;
            $display("FAIL stray_err_ack t=%0t got err=%b ack_z=%b want 0 0", $time, err, ack_z);
        end
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic chk_rd(input logic [2:0] idx, input logic [15:0] e, input logic [15:0] ez);
        rd_addr = {idx, idx};
        #1;
        for (int p = 0; p < 2; p++) begin
            chk(rd_data[p*16 +: 16] === e, $sformatf("rd_p%0d_idx%0d", p, idx),
                {16'h0, rd_data[p*16 +: 16]}, {16'h0, e});
            chk(rd_data_z[p*16 +: 16] === ez, $sformatf("rdz_p%0d_idx%0d", p, idx),
                {16'h0, rd_data_z[p*16 +: 16]}, {16'h0, ez});
        end
    endtask

    task automatic chk_all();
        for (int i = 0; i < 8; i++) chk_rd(3'(i), m[i], mz[i]);
    endtask

    // Issues one transfer; returns 1 time unit after the accept edge.
    task automatic bus_op(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] er, input logic ee, input logic [15:0] erz,
                          input bit push);
        int n = 0;
        while (rdy !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk(rdy === 1'b1, "rdy_wait", {31'h0, rdy}, 32'h1);
        cs = 1'b1; req = 1'b1; write = w; address = a; wdata = d;
        if (push) sb_q.push_back('{er, ee, erz});
        @(posedge clk); #1;
        cs = 1'b0; req = 1'b0;
        chk(rdy === 1'b0 && ack === 1'b0, "access_state", {30'h0, rdy, ack}, 32'h0);
    endtask

    // Commit edge (optionally with a datapath write), ack cycle, back to idle.
    task automatic finish_op(input bit dpw, input logic [2:0] di, input logic [15:0] dd);
        dp_we = dpw; dp_waddr = di; dp_wdata = dd;
        @(posedge clk); #1;
        dp_we = 1'b0;
        chk(ack === 1'b1 && rdy === 1'b0, "ack_pulse", {30'h0, ack, rdy}, 32'h2);
        @(posedge clk); #1;
        chk(ack === 1'b0 && rdy === 1'b1, "rdy_back", {30'h0, ack, rdy}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; req = 1'b0; write = 1'b0; address = '0; wdata = '0;
        dp_we = 1'b0; dp_waddr = '0; dp_wdata = '0; rd_addr = '0;
        for (int i = 0; i < 8; i++) begin m[i] = '0; mz[i] = '0; end

        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk(rdy === 1'b1 && rdy_z === 1'b1, "reset_rdy", {30'h0, rdy, rdy_z}, 32'h3);
        chk(ack === 1'b0 && err === 1'b0, "reset_ack_err", {30'h0, ack, err}, 32'h0);
        chk(rdata === 16'h0, "reset_rdata", {16'h0, rdata}, 32'h0);
        chk_all();

        // Store A5A5 to 3: invisible until the commit edge, visible after
        bus_op(1'b1, 16'd3, 16'hA5A5, 16'h0000, 1'b0, 16'h0000, 1'b1);
        chk_rd(3'd3, 16'h0000, 16'h0000);
        finish_op(1'b0, 3'd0, 16'h0);
        m[3] = 16'hA5A5; mz[3] = 16'hA5A5;
        chk_rd(3'd3, 16'hA5A5, 16'hA5A5);

        // Load from 3
        bus_op(1'b0, 16'd3, 16'h0, 16'hA5A5, 1'b0, 16'hA5A5, 1'b1);
        finish_op(1'b0, 3'd0, 16'h0);
        chk(rdata === 16'hA5A5, "rdata_hold", {16'h0, rdata}, 32'hA5A5);

        // Out-of-range store (rdata keeps last load) and load
        bus_op(1'b1, 16'd8, 16'h1234, 16'hA5A5, 1'b1, 16'hA5A5, 1'b1);
        finish_op(1'b0, 3'd0, 16'h0);
        chk_all();
        bus_op(1'b0, 16'hFFFF, 16'h0, 16'h0000, 1'b1, 16'h0000, 1'b1);
        finish_op(1'b0, 3'd0, 16'h0);
        chk(err === 1'b0, "err_clears", {31'h0, err}, 32'h0);

        // Collision, same index: datapath wins
        bus_op(1'b1, 16'd5, 16'h1111, 16'h0000, 1'b0, 16'h0000, 1'b1);
        finish_op(1'b1, 3'd5, 16'h2222);
        m[5] = 16'h2222; mz[5] = 16'h2222;
        chk_rd(3'd5, m[5], mz[5]);

        // Collision, different indices: both commit
        bus_op(1'b1, 16'd5, 16'h1111, 16'h0000, 1'b0, 16'h0000, 1'b1);
        finish_op(1'b1, 3'd6, 16'h2222);
        m[5] = 16'h1111; mz[5] = 16'h1111;
        m[6] = 16'h2222; mz[6] = 16'h2222;
        chk_all();
        bus_op(1'b0, 16'd5, 16'h0, 16'h1111, 1'b0, 16'h1111, 1'b1);
        finish_op(1'b0, 3'd0, 16'h0);

        // Datapath write alone: one-edge latency, no bypass
        dp_we = 1'b1; dp_waddr = 3'd7; dp_wdata = 16'h7777;
        chk_rd(3'd7, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        dp_we = 1'b0;
        m[7] = 16'h7777; mz[7] = 16'h7777;
        chk_rd(3'd7, 16'h7777, 16'h7777);

        // Index 0: bus FFFF and dp 0F0F on the same edge; dropped only when ZERO_REG=1
        bus_op(1'b1, 16'd0, 16'hFFFF, 16'h1111, 1'b0, 16'h1111, 1'b1);
        finish_op(1'b1, 3'd0, 16'h0F0F);
        m[0] = 16'h0F0F; mz[0] = 16'h0000;
        chk_all();
        bus_op(1'b0, 16'd0, 16'h0, 16'h0F0F, 1'b0, 16'h0000, 1'b1);
        finish_op(1'b0, 3'd0, 16'h0);

        // Reset while a store to 2 is in ACCESS: no commit, no ack
        bus_op(1'b1, 16'd2, 16'hBEEF, 16'h0, 1'b0, 16'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk(rdy === 1'b1 && ack === 1'b0, "midop_rdy", {30'h0, rdy, ack}, 32'h2);
        chk(rdata === 16'h0 && rdata_z === 16'h0, "midop_rdata", {rdata, rdata_z}, 32'h0);
        for (int i = 0; i < 8; i++) begin m[i] = '0; mz[i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        chk_all();

        chk(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
